soc_system_pio_keys: RTL and testbench
======================================

SOC_SYSTEM_PIO_KEYS -- requirements
Module: soc_system_pio_keys

Interface
REQ-001 Parameter WIDTH, default 8: number of input pins; legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required before a pin change is accepted; values 0 and 1 behave identically.
REQ-003 Parameter EDGE_TYPE, default 1: edge that sets a capture bit; 0 = rising, 1 = falling, 2 = any.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 address  input  2  Avalon-MM word address.
REQ-008 chipselect  input  1  Avalon-MM slave select; qualifies writes only.
REQ-009 write_n  input  1  Avalon-MM active-low write strobe.
REQ-010 writedata  input  32  Avalon-MM write data.
REQ-011 in_port  input  WIDTH  asynchronous external pins; idle level high.
REQ-012 readdata  output  32  Avalon-MM read data; read latency 0; combinational from address and registers.
REQ-013 irq  output  1  level interrupt, active high.

Function
REQ-014 Register map: 0 = DATA (RO, debounced pins), 1 = IRQ_MASK (RW, WIDTH bits), 2 = reserved (reads 0, writes ignored), 3 = EDGE_CAPTURE (read; write-1-to-clear).
REQ-015 readdata = selected register zero-extended to 32 bits; reads are independent of chipselect and have no side effects.
REQ-016 A write occurs on a clock edge with chipselect=1 and write_n=0; only writedata[WIDTH-1:0] is used.
REQ-017 Each pin passes through a two-flop synchronizer (s1, s2) before any other use.
REQ-018 Per pin, one debounce counter of ceil(log2(max(DEBOUNCE_CYCLES,2))) bits: cleared on every edge where s2 equals the stable bit; incremented on every edge where they differ.
REQ-019 The stable bit loads s2 on the edge where s2 differs from it and the counter equals max(DEBOUNCE_CYCLES,1)-1; the counter clears on the same edge.
REQ-020 Latency: with in_port changed and held before edge 0, the stable bit updates at edge 2+max(DEBOUNCE_CYCLES,1).
REQ-021 A glitch shorter than max(DEBOUNCE_CYCLES,1) cycles at s2 leaves the stable bit and the capture bit unchanged.
REQ-022 Edge detection compares the stable bit against its one-cycle-delayed copy; a detected edge of type EDGE_TYPE sets the capture bit on the following edge, i.e. at edge 3+max(DEBOUNCE_CYCLES,1).
REQ-023 A capture bit stays set until cleared by writing 1 to that bit at address 3; writing 0 has no effect.
REQ-024 When a clear and a new edge hit the same bit on the same clock edge, the bit remains set.
REQ-025 irq = OR over bits of (EDGE_CAPTURE AND IRQ_MASK), combinational from registers; it therefore tracks mask writes and capture clears with no additional cycle of delay.
REQ-026 Counters saturate logically through REQ-019; they never wrap.

Reset
REQ-027 While reset_n=0: s1, s2, stable and delayed-stable bits are all ones; counters, IRQ_MASK and EDGE_CAPTURE are zero; irq=0.
REQ-028 Release of reset with in_port held high generates no edge; with in_port held low and EDGE_TYPE 1 or 2, one falling edge is captured after the REQ-022 latency.
REQ-029 Reset asserted mid-debounce discards the count with no partial update.

Structure
REQ-030 The register address constants (DATA, IRQ_MASK, EDGE_CAPTURE) and the EDGE_TYPE encodings live in the shared package soc_system_pio_pkg.
REQ-031 The synchronizer, counter and stable bit form the sub-module soc_system_pio_debounce, which is instantiated once per pin; edge detection, the registers and the bus decode stay in the top level.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1 unless noted)
REQ-032 Reset release with in_port=4'hF -> DATA reads 0xF, EDGE_CAPTURE reads 0, irq=0 throughout.
REQ-033 in_port bit0 driven low before edge 0 and held -> DATA bit0=0 from edge 6, EDGE_CAPTURE=0x1 from edge 7; irq stays 0 while IRQ_MASK=0; writing IRQ_MASK=0x1 -> irq=1 immediately after that write edge.
REQ-034 3-cycle low glitch on bit1 -> DATA stays 0xF and EDGE_CAPTURE stays 0; a 4-cycle low pulse sets capture bit1.
REQ-035 With EDGE_CAPTURE=0x3 and IRQ_MASK=0xF, writing 0x1 to address 3 -> EDGE_CAPTURE=0x2 and irq=1; then writing 0x2 -> EDGE_CAPTURE=0 and irq=0.
REQ-036 A clear of bit2 written on the same edge that a new falling edge on bit2 is captured -> bit2 reads 1.
REQ-037 EDGE_TYPE=2 with DEBOUNCE_CYCLES=0 -> a low then high toggle of bit3 captures at edge 4 after each change; reset_n pulsed low mid-debounce -> no capture occurs.

Source files
------------

// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the PIO key block: register word addresses and edge-type encodings.
// No logic; consumed at elaboration time only.
// Not applicable (no handshake).
package soc_system_pio_pkg;

  // Avalon-MM word addresses
  localparam logic [1:0] ADDR_DATA         = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK     = 2'd1;
  localparam logic [1:0] ADDR_RESERVED     = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd3;

  // EDGE_TYPE encodings
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Effective debounce length: 0 and 1 both mean a single stable cycle.
  function automatic int unsigned debounce_len(input int unsigned cycles);
    return (cycles < 1) ? 1 : cycles;
  endfunction

  // Counter width for a given debounce setting; at least one bit.
  function automatic int unsigned debounce_cw(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/soc_system_pio_debounce.sv
// One-pin synchronizer plus debounce filter producing a stable level.
// Latency: stable follows a held pin change 2+max(DEBOUNCE_CYCLES,1) edges later.
// No backpressure; free-running per clock.
module soc_system_pio_debounce
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic stable
);

  localparam int unsigned CW   = debounce_cw(DEBOUNCE_CYCLES);
  localparam int unsigned LEN  = debounce_len(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer, then count consecutive cycles that s2 disagrees with stable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Change held long enough: accept it; counter restarts so it never wraps
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_system_pio_keys.sv
// Debounced key PIO with edge capture and level interrupt on an Avalon-MM slave.
// Latency: reads 0 cycles; capture bit sets 3+max(DEBOUNCE_CYCLES,1) edges after a pin change.
// No backpressure: slave never stalls, writes take effect on the strobe edge.
module soc_system_pio_keys
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    soc_system_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (in_port[i]),
      .stable (stable[i])
    );
  end

  assign wr_en   = chipselect & ~write_n;
  assign wr_bits = WIDTH'(writedata);

  // Select which stable-level transitions count as an edge
  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_hit = stable & ~stable_d;
      EDGE_FALLING: edge_hit = ~stable & stable_d;
      default:      edge_hit = stable ^ stable_d;
    endcase
  end

  // Write-1-to-clear mask for the capture register
  always_comb begin
    clr_bits = '0;
    if (wr_en && address == ADDR_EDGE_CAPTURE) clr_bits = wr_bits;
  end

  // Delayed stable copy, mask register and capture register; a new edge wins over a clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d     <= '1;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      stable_d     <= stable;
      edge_capture <= (edge_capture & ~clr_bits) | edge_hit;
      if (wr_en && address == ADDR_IRQ_MASK) irq_mask <= wr_bits;
    end
  end

  // Zero-latency read mux; reserved address reads zero
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:         readdata = 32'(stable);
      ADDR_IRQ_MASK:     readdata = 32'(irq_mask);
      ADDR_EDGE_CAPTURE: readdata = 32'(edge_capture);
      default:           readdata = '0;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_soc_system_pio_keys.sv
// Directed bench: two instances, (4,4,falling) and (4,0,any), driven from one clock.
// Edge N is counted as the Nth rising edge after inputs are changed just past edge 0.
// Outputs sampled 1-2 time units after the active edge.
module tb_soc_system_pio_keys;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1
  logic        a_reset_n, a_chipselect, a_write_n, a_irq;
  logic [1:0]  a_address;
  logic [31:0] a_writedata, a_readdata;
  logic [3:0]  a_in_port;

  // Instance B: WIDTH=4, DEBOUNCE_CYCLES=0, EDGE_TYPE=2
  logic        b_reset_n, b_chipselect, b_write_n, b_irq;
  logic [1:0]  b_address;
  logic [31:0] b_writedata, b_readdata;
  logic [3:0]  b_in_port;

  soc_system_pio_keys #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut_a (
    .clk(clk), .reset_n(a_reset_n), .address(a_address), .chipselect(a_chipselect),
    .write_n(a_write_n), .writedata(a_writedata), .in_port(a_in_port),
    .readdata(a_readdata), .irq(a_irq)
  );

  soc_system_pio_keys #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset_n(b_reset_n), .address(b_address), .chipselect(b_chipselect),
    .write_n(b_write_n), .writedata(b_writedata), .in_port(b_in_port),
    .readdata(b_readdata), .irq(b_irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, leave time 1 unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Combinational read of instance sel (0=A, 1=B)
  task automatic rd(input bit sel, input logic [1:0] addr, output logic [31:0] data);
    if (!sel) a_address = addr; else b_address = addr;
    #1;
    data = sel ? b_readdata : a_readdata;
  endtask

  // One write strobe; the write lands on the next rising edge
  task automatic wr(input bit sel, input logic [1:0] addr, input logic [31:0] data);
    if (!sel) begin
      a_address = addr; a_writedata = data; a_chipselect = 1'b1; a_write_n = 1'b0;
    end else begin
      b_address = addr; b_writedata = data; b_chipselect = 1'b1; b_write_n = 1'b0;
    end
    tick(1);
    a_chipselect = 1'b0; a_write_n = 1'b1;
    b_chipselect = 1'b0; b_write_n = 1'b1;
  endtask

  logic [31:0] rv;

  initial begin
    a_reset_n = 1'b0; a_chipselect = 1'b0; a_write_n = 1'b1; a_address = 2'd0;
    a_writedata = '0; a_in_port = 4'hF;
    b_reset_n = 1'b0; b_chipselect = 1'b0; b_write_n = 1'b1; b_address = 2'd0;
    b_writedata = '0; b_in_port = 4'hF;
    tick(3);

    // Reset state
    rd(0, 2'd0, rv); check("rst_data", rv, 32'hF);
    rd(0, 2'd1, rv); check("rst_mask", rv, 32'h0);
    rd(0, 2'd3, rv); check("rst_cap", rv, 32'h0);
    check("rst_irq", {31'b0, a_irq}, 32'h0);

    // Release with pins high: no edge
    a_reset_n = 1'b1; b_reset_n = 1'b1;
    tick(10);
    rd(0, 2'd0, rv); check("rel_data", rv, 32'hF);
    rd(0, 2'd3, rv); check("rel_cap", rv, 32'h0);
    check("rel_irq", {31'b0, a_irq}, 32'h0);

    // Bit0 held low: DATA changes at edge 6, capture at edge 7
    a_in_port = 4'hE;
    tick(5);
    rd(0, 2'd0, rv); check("b0_data_e5", rv, 32'hF);
    tick(1);
    rd(0, 2'd0, rv); check("b0_data_e6", rv, 32'hE);
    rd(0, 2'd3, rv); check("b0_cap_e6", rv, 32'h0);
    tick(1);
    rd(0, 2'd3, rv); check("b0_cap_e7", rv, 32'h1);
    check("b0_irq_nomask", {31'b0, a_irq}, 32'h0);
    wr(0, 2'd1, 32'h1);
    check("b0_irq_mask", {31'b0, a_irq}, 32'h1);
    wr(0, 2'd1, 32'h0);
    check("b0_irq_unmask", {31'b0, a_irq}, 32'h0);

    // Restore high (rising edge ignored), clear bit0
    a_in_port = 4'hF;
    tick(10);
    rd(0, 2'd3, rv); check("rise_ignored", rv, 32'h1);
    wr(0, 2'd3, 32'h0);
    rd(0, 2'd3, rv); check("w0_noclear", rv, 32'h1);
    wr(0, 2'd3, 32'h1);
    rd(0, 2'd3, rv); check("w1_clear", rv, 32'h0);
    wr(0, 2'd2, 32'hF);
    rd(0, 2'd2, rv); check("reserved", rv, 32'h0);

    // 3-cycle glitch on bit1 is filtered
    a_in_port = 4'hD; tick(3); a_in_port = 4'hF;
    tick(12);
    rd(0, 2'd0, rv); check("glitch_data", rv, 32'hF);
    rd(0, 2'd3, rv); check("glitch_cap", rv, 32'h0);

    // 4-cycle pulse on bit1 is accepted
    a_in_port = 4'hD; tick(4); a_in_port = 4'hF;
    tick(14);
    rd(0, 2'd3, rv); check("pulse4_cap", rv, 32'h2);
    rd(0, 2'd0, rv); check("pulse4_data", rv, 32'hF);

    // Build capture 0x3, then clear one bit at a time
    a_in_port = 4'hE; tick(10); a_in_port = 4'hF; tick(10);
    rd(0, 2'd3, rv); check("cap3", rv, 32'h3);
    wr(0, 2'd1, 32'hF);
    check("irq_cap3", {31'b0, a_irq}, 32'h1);
    wr(0, 2'd3, 32'h1);
    rd(0, 2'd3, rv); check("clr1_cap", rv, 32'h2);
    check("clr1_irq", {31'b0, a_irq}, 32'h1);
    wr(0, 2'd3, 32'h2);
    rd(0, 2'd3, rv); check("clr2_cap", rv, 32'h0);
    check("clr2_irq", {31'b0, a_irq}, 32'h0);

    // Clear and new edge on bit2 at the same edge (edge 7): bit stays set
    a_in_port = 4'hB;
    tick(6);
    wr(0, 2'd3, 32'h4);
    rd(0, 2'd3, rv); check("clr_vs_edge", rv, 32'h4);
    wr(0, 2'd3, 32'h4);
    rd(0, 2'd3, rv); check("clr_after", rv, 32'h0);
    a_in_port = 4'hF;
    tick(10);

    // Reset mid-debounce on A discards the count
    a_in_port = 4'hE;
    tick(4);
    a_reset_n = 1'b0; tick(1);
    a_in_port = 4'hF; a_reset_n = 1'b1;
    tick(12);
    rd(0, 2'd3, rv); check("a_rstmid_cap", rv, 32'h0);
    rd(0, 2'd0, rv); check("a_rstmid_data", rv, 32'hF);
    rd(0, 2'd1, rv); check("a_rstmid_mask", rv, 32'h0);

    // Instance B: any edge, single-cycle debounce; capture at edge 4
    b_in_port = 4'h7;
    tick(2);
    rd(1, 2'd0, rv); check("b_fall_data_e2", rv, 32'hF);
    tick(1);
    rd(1, 2'd0, rv); check("b_fall_data_e3", rv, 32'h7);
    rd(1, 2'd3, rv); check("b_fall_cap_e3", rv, 32'h0);
    tick(1);
    rd(1, 2'd3, rv); check("b_fall_cap_e4", rv, 32'h8);
    wr(1, 2'd3, 32'h8);
    rd(1, 2'd3, rv); check("b_fall_clr", rv, 32'h0);
    tick(2);

    b_in_port = 4'hF;
    tick(3);
    rd(1, 2'd3, rv); check("b_rise_cap_e3", rv, 32'h0);
    tick(1);
    rd(1, 2'd3, rv); check("b_rise_cap_e4", rv, 32'h8);
    check("b_irq_nomask", {31'b0, b_irq}, 32'h0);
    wr(1, 2'd3, 32'h8);
    tick(2);

    // Reset pulsed on B before the change is accepted
    b_in_port = 4'h7;
    tick(2);
    b_reset_n = 1'b0; tick(1);
    b_in_port = 4'hF; b_reset_n = 1'b1;
    tick(8);
    rd(1, 2'd3, rv); check("b_rstmid_cap", rv, 32'h0);
    rd(1, 2'd0, rv); check("b_rstmid_data", rv, 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
